// File: rtl/pio_pwm_pkg.sv
// Shared definitions for the PIO-driven soft-start PWM bridge.
//   state_e  : FSM state encoding, also exported on state_o for readback
//   STATE_W  : width of the state encoding
//   sat_add  : add with an upper clamp
//   sat_sub  : subtract clamped at zero (no wrap)
package pio_pwm_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        RUN       = 3'd2,
        RAMP_DOWN = 3'd3,
        DEAD      = 3'd4
    } state_e;

    function automatic int unsigned sat_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned lim);
        int unsigned s;
        s = a + b;
        return (s > lim) ? lim : s;
    endfunction

    function automatic int unsigned sat_sub(input int unsigned a,
                                            input int unsigned b);
        return (a > b) ? (a - b) : 0;
    endfunction

endpackage

// File: rtl/pio_pwm_ramp_sync.sv
// Multi-flop synchronizer for the 2-bit PIO control word.
//   clk, reset_n : clock, asynchronous active-low reset (chain clears to 0)
//   ctrl_in      : asynchronous control bits from the PIO
//   ctrl_sync    : control bits after SYNC_STAGES flops
module pio_ctrl_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] ctrl_in,
    output logic [1:0] ctrl_sync
);

    logic [SYNC_STAGES-1:0][1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], ctrl_in};
        end
    end

    assign ctrl_sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pio_pwm_ramp.sv
// Soft-started, dead-timed H-bridge PWM driven by PIO control bits.
//   clk, reset_n : clock, asynchronous active-low reset
//   ctrl_in      : [0]=run, [1]=direction (0=side A, 1=side B)
//   pwm_a, pwm_b : bridge drives, never high together
//   duty_o       : currently applied duty (on-cycles per period)
//   busy         : high whenever the FSM is not IDLE
//   state_o      : FSM state for debug/readback
module pio_pwm_ramp
    import pio_pwm_pkg::*;
#(
    parameter int unsigned PERIOD      = 1000,
    parameter int unsigned DUTY_MAX    = 800,
    parameter int unsigned RAMP_STEP   = 8,
    parameter int unsigned DEAD_CYCLES = 50,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         ctrl_in,
    output logic               pwm_a,
    output logic               pwm_b,
    output logic [CNT_W-1:0]   duty_o,
    output logic               busy,
    output logic [STATE_W-1:0] state_o
);

    localparam int unsigned DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  DMAX      = CNT_W'(DUTY_MAX);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);

    logic [1:0]        ctrl_sync;
    logic              run;
    logic              dir_req;
    logic [CNT_W-1:0]  cnt;
    logic              bnd;
    logic [CNT_W-1:0]  duty;
    logic              dir_act;
    logic [DEAD_W-1:0] dead_cnt;
    state_e            state;
    logic              pwm_on;
    logic              drive_en;
    logic              stop_req;
    logic [CNT_W-1:0]  duty_up;
    logic [CNT_W-1:0]  duty_dn;
    logic [CNT_W-1:0]  duty_first;

    pio_ctrl_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .ctrl_in  (ctrl_in),
        .ctrl_sync(ctrl_sync)
    );

    assign run      = ctrl_sync[0];
    assign dir_req  = ctrl_sync[1];
    assign bnd      = (cnt == CNT_LAST);
    assign stop_req = !run || (dir_req != dir_act);

    assign duty_first = CNT_W'(sat_add(0, RAMP_STEP, DUTY_MAX));
    assign duty_up    = CNT_W'(sat_add(32'(duty), RAMP_STEP, DUTY_MAX));
    assign duty_dn    = CNT_W'(sat_sub(32'(duty), RAMP_STEP));

    // Free-running period counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (bnd) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Duty is only ever written on a period boundary so each period is whole.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            duty     <= '0;
            dir_act  <= 1'b0;
            dead_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run && bnd) begin
                        dir_act <= dir_req;
                        duty    <= duty_first;
                        state   <= (duty_first == DMAX) ? RUN : RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    // A stop takes priority over a coincident boundary step.
                    if (stop_req) begin
                        state <= RAMP_DOWN;
                    end else if (bnd) begin
                        duty <= duty_up;
                        if (duty_up == DMAX) state <= RUN;
                    end
                end
                RUN: begin
                    if (stop_req) state <= RAMP_DOWN;
                end
                RAMP_DOWN: begin
                    if (bnd) begin
                        duty <= duty_dn;
                        if (duty_dn == '0) begin
                            state    <= DEAD;
                            dead_cnt <= DEAD_LOAD;
                        end
                    end
                end
                DEAD: begin
                    if (dead_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        dead_cnt <= dead_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_on <= 1'b0;
        end else begin
            pwm_on <= (cnt < duty);
        end
    end

    assign drive_en = (state == RAMP_UP) || (state == RUN) || (state == RAMP_DOWN);
    assign pwm_a    = pwm_on & ~dir_act & drive_en;
    assign pwm_b    = pwm_on &  dir_act & drive_en;
    assign duty_o   = duty;
    assign busy     = (state != IDLE);
    assign state_o  = state;

endmodule

// File: tb/tb_pio_pwm_ramp.sv
// Self-checking bench for pio_pwm_ramp: two instances (RAMP_STEP 4 and 5)
// share clock, reset and control; a behavioural model predicts every cycle.
module tb_pio_pwm_ramp;
    import pio_pwm_pkg::*;

    localparam int P  = 20;
    localparam int DM = 12;
    localparam int DC = 5;
    localparam int SS = 2;
    localparam int CW = 5;

    logic          clk;
    logic          reset_n;
    logic [1:0]    ctrl_in;
    logic          pwm_a  [2];
    logic          pwm_b  [2];
    logic [CW-1:0] duty_o [2];
    logic          busy   [2];
    logic [2:0]    state_o[2];

    int n_pass = 0;
    int n_checks = 0;

    pio_pwm_ramp #(.PERIOD(P), .DUTY_MAX(DM), .RAMP_STEP(4), .DEAD_CYCLES(DC),
                   .SYNC_STAGES(SS), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .ctrl_in(ctrl_in),
        .pwm_a(pwm_a[0]), .pwm_b(pwm_b[0]), .duty_o(duty_o[0]),
        .busy(busy[0]), .state_o(state_o[0]));

    pio_pwm_ramp #(.PERIOD(P), .DUTY_MAX(DM), .RAMP_STEP(5), .DEAD_CYCLES(DC),
                   .SYNC_STAGES(SS), .CNT_W(CW)) dut5 (
        .clk(clk), .reset_n(reset_n), .ctrl_in(ctrl_in),
        .pwm_a(pwm_a[1]), .pwm_b(pwm_b[1]), .duty_o(duty_o[1]),
        .busy(busy[1]), .state_o(state_o[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    int         m_cnt;
    logic [1:0] m_sync[SS];
    int         m_duty[2];
    int         m_dir[2];
    int         m_dead[2];
    int         m_on[2];
    state_e     m_ph[2];
    int         steps[2] = '{4, 5};

    // bench-side observers on the STEP=4 instance
    int dead_run = 0;
    int low_run = 0;
    int last_side = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        for (int i = 0; i < SS; i++) m_sync[i] = 2'b00;
        for (int i = 0; i < 2; i++) begin
            m_duty[i] = 0; m_dir[i] = 0; m_dead[i] = 0; m_on[i] = 0; m_ph[i] = IDLE;
        end
    endtask

    task automatic model_step(input logic [1:0] c);
        bit boundary;
        int run;
        int dreq;
        boundary = (m_cnt == P - 1);
        run  = int'(m_sync[SS-1][0]);
        dreq = int'(m_sync[SS-1][1]);
        for (int i = 0; i < 2; i++) begin
            int on_next;
            on_next = (m_cnt < m_duty[i]) ? 1 : 0;
            case (m_ph[i])
                IDLE: if (run == 1 && boundary) begin
                    m_dir[i]  = dreq;
                    m_duty[i] = imin(steps[i], DM);
                    m_ph[i]   = (m_duty[i] == DM) ? RUN : RAMP_UP;
                end
                RAMP_UP: if (run == 0 || dreq != m_dir[i]) m_ph[i] = RAMP_DOWN;
                         else if (boundary) begin
                             m_duty[i] = imin(m_duty[i] + steps[i], DM);
                             if (m_duty[i] == DM) m_ph[i] = RUN;
                         end
                RUN: if (run == 0 || dreq != m_dir[i]) m_ph[i] = RAMP_DOWN;
                RAMP_DOWN: if (boundary) begin
                    m_duty[i] = (m_duty[i] > steps[i]) ? m_duty[i] - steps[i] : 0;
                    if (m_duty[i] == 0) begin
                        m_ph[i] = DEAD;
                        m_dead[i] = DC - 1;
                    end
                end
                default: if (m_dead[i] == 0) m_ph[i] = IDLE; else m_dead[i]--;
            endcase
            m_on[i] = on_next;
        end
        m_cnt = (m_cnt + 1) % P;
        for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = c;
    endtask

    function automatic logic [10:0] exp_vec(input int i);
        logic drv, a, b;
        drv = (m_ph[i] == RAMP_UP) || (m_ph[i] == RUN) || (m_ph[i] == RAMP_DOWN);
        a = drv && m_on[i] == 1 && m_dir[i] == 0;
        b = drv && m_on[i] == 1 && m_dir[i] == 1;
        return {a, b, (m_ph[i] != IDLE), 3'(m_ph[i]), CW'(m_duty[i])};
    endfunction

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            logic [10:0] act;
            act = {pwm_a[i], pwm_b[i], busy[i], state_o[i], duty_o[i]};
            chk(i == 0 ? "cycle_step4" : "cycle_step5", int'(act), int'(exp_vec(i)));
            chk("excl_ab", int'(pwm_a[i] & pwm_b[i]), 0);
        end
        if (reset_n) begin
            if (state_o[0] == 3'(DEAD)) dead_run++;
            else if (dead_run > 0) begin
                chk("dead_len", dead_run, DC);
                dead_run = 0;
            end
            if (pwm_a[0] || pwm_b[0]) begin
                int side;
                side = pwm_a[0] ? 1 : 2;
                if (last_side != 0 && side != last_side) chk("rev_gap_ge5", int'(low_run >= DC), 1);
                last_side = side;
                low_run = 0;
            end else begin
                low_run++;
            end
        end else begin
            dead_run = 0; low_run = 0; last_side = 0;
        end
    endtask

    task automatic cycle(input logic [1:0] c);
        ctrl_in = c;
        @(posedge clk);
        if (reset_n) model_step(c);
        else model_reset();
        @(negedge clk);
        compare_all();
    endtask

    // ---------------- table ----------------
    typedef struct {
        logic [1:0] ctrl;
        state_e     st4;
        int         d4;
        state_e     st5;
        int         d5;
        int         ha;
        int         hb;
    } row_t;

    row_t rows[18];

    initial begin
        int ha, hb, found;
        rows[0]  = '{2'b00, IDLE,      0,  IDLE,      0,  0,  0};
        rows[1]  = '{2'b01, RAMP_UP,   4,  RAMP_UP,   5,  0,  0};
        rows[2]  = '{2'b01, RAMP_UP,   8,  RAMP_UP,   10, 4,  0};
        rows[3]  = '{2'b01, RUN,       12, RUN,       12, 8,  0};
        rows[4]  = '{2'b01, RUN,       12, RUN,       12, 12, 0};
        rows[5]  = '{2'b00, RAMP_DOWN, 8,  RAMP_DOWN, 7,  12, 0};
        rows[6]  = '{2'b00, RAMP_DOWN, 4,  RAMP_DOWN, 2,  8,  0};
        rows[7]  = '{2'b00, DEAD,      0,  DEAD,      0,  4,  0};
        rows[8]  = '{2'b00, IDLE,      0,  IDLE,      0,  0,  0};
        rows[9]  = '{2'b11, RAMP_UP,   4,  RAMP_UP,   5,  0,  0};
        rows[10] = '{2'b11, RAMP_UP,   8,  RAMP_UP,   10, 0,  4};
        rows[11] = '{2'b11, RUN,       12, RUN,       12, 0,  8};
        rows[12] = '{2'b01, RAMP_DOWN, 8,  RAMP_DOWN, 7,  0,  12};
        rows[13] = '{2'b01, RAMP_DOWN, 4,  RAMP_DOWN, 2,  0,  8};
        rows[14] = '{2'b01, DEAD,      0,  DEAD,      0,  0,  4};
        rows[15] = '{2'b01, RAMP_UP,   4,  RAMP_UP,   5,  0,  0};
        rows[16] = '{2'b00, DEAD,      0,  DEAD,      0,  4,  0};
        rows[17] = '{2'b00, IDLE,      0,  IDLE,      0,  0,  0};

        // Reset window with run+dir requested: everything must stay quiet.
        reset_n = 1'b0;
        ctrl_in = 2'b11;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            cycle(2'b11);
            chk("rst_outputs", int'({pwm_a[0], pwm_b[0], busy[0], duty_o[0]}), 0);
            chk("rst_state", int'(state_o[0]), int'(IDLE));
        end
        ctrl_in = 2'b00;
        reset_n = 1'b1;

        // Period-by-period table; each row is exactly one PWM period.
        for (int r = 0; r < 18; r++) begin
            ha = 0; hb = 0;
            for (int k = 0; k < P; k++) begin
                cycle(rows[r].ctrl);
                ha += int'(pwm_a[0]);
                hb += int'(pwm_b[0]);
            end
            chk($sformatf("row%0d_state4", r), int'(state_o[0]), int'(rows[r].st4));
            chk($sformatf("row%0d_duty4", r), int'(duty_o[0]), rows[r].d4);
            chk($sformatf("row%0d_state5", r), int'(state_o[1]), int'(rows[r].st5));
            chk($sformatf("row%0d_duty5", r), int'(duty_o[1]), rows[r].d5);
            chk($sformatf("row%0d_high_a", r), ha, rows[r].ha);
            chk($sformatf("row%0d_high_b", r), hb, rows[r].hb);
        end

        // Randomized control changes against the model.
        for (int seg = 0; seg < 40; seg++) begin
            logic [1:0] c;
            int len;
            c = 2'($urandom_range(0, 3));
            len = int'($urandom_range(1, 45));
            for (int k = 0; k < len; k++) cycle(c);
        end

        // Asynchronous reset in the middle of RUN while pwm_a is high.
        found = 0;
        for (int k = 0; k < 400 && found == 0; k++) begin
            cycle(2'b01);
            if (m_ph[0] == RUN && m_dir[0] == 0 && m_on[0] == 1) found = 1;
        end
        chk("reach_run_high", found, 1);
        chk("pre_rst_pwm_a", int'(pwm_a[0]), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_pwm_a", int'(pwm_a[0]), 0);
        chk("async_rst_busy", int'(busy[0]), 0);
        chk("async_rst_duty", int'(duty_o[0]), 0);
        chk("async_rst_state", int'(state_o[0]), int'(IDLE));
        model_reset();
        cycle(2'b01);
        cycle(2'b01);
        reset_n = 1'b1;
        for (int k = 0; k < 3 * P; k++) cycle(2'b01);
        chk("restart_state4", int'(state_o[0]), int'(RUN));
        chk("restart_duty4", int'(duty_o[0]), 12);
        chk("restart_duty5", int'(duty_o[1]), 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pio_pwm_ramp.md
Name: pio_pwm_ramp

Overview:
Downstream consumer of the 2-bit Avalon PIO output word. It turns the PIO software control bits (bit0 = run, bit1 = direction) into a soft-started, dead-timed H-bridge PWM pair for a motor/LED driver. The block has its own synchronizer on the control bits. Its free-running PWM period counter updates duty only at period boundaries, so the outputs are glitch-free.

Parameters:
PERIOD, 1000, PWM period in clk cycles (>=2)
DUTY_MAX, 800, steady-state on-cycles per period (1..PERIOD)
RAMP_STEP, 8, duty change per period during ramps (>=1)
DEAD_CYCLES, 50, clk cycles with both outputs low after ramp-down (>=1)
SYNC_STAGES, 2, synchronizer depth on ctrl_in (>=2)
CNT_W, 10, counter/duty width; must hold PERIOD-1 and DUTY_MAX

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
ctrl_in  in  2  from PIO out_port; [0]=run, [1]=dir (0=A, 1=B)
pwm_a  out  1  bridge side A drive
pwm_b  out  1  bridge side B drive
duty_o  out  CNT_W  current applied duty
busy  out  1  high whenever state != IDLE
state_o  out  3  FSM state encoding, for debug/readback

Behaviour:
- Reset is asynchronous, active-low on clk. All flops clear: sync chain 0, cnt 0, duty 0, dir_act 0, dead counter 0, state IDLE. Outputs pwm_a, pwm_b, duty_o and busy are 0; state_o is IDLE.
- Sync: ctrl_in passes through SYNC_STAGES flops. run and dir_req are the last stage. The FSM sees a ctrl change SYNC_STAGES cycles later.
- Period counter: cnt runs 0..PERIOD-1 and wraps to 0; it always counts. bnd = (cnt == PERIOD-1).
- Duty register is written only in cycles where bnd=1.
- FSM states:
  - IDLE: duty=0. If run and bnd: dir_act<=dir_req, duty<=min(RAMP_STEP,DUTY_MAX), go RAMP_UP. If that value equals DUTY_MAX, go RUN instead.
  - RAMP_UP: if !run or dir_req!=dir_act, go RAMP_DOWN on any cycle. A stop wins over a coincident bnd: no increment in that cycle. Otherwise, on bnd: duty<=min(duty+RAMP_STEP,DUTY_MAX); go RUN when the new duty equals DUTY_MAX.
  - RUN: if !run or dir_req!=dir_act, go RAMP_DOWN on any cycle.
  - RAMP_DOWN: on bnd, duty<=max(duty-RAMP_STEP,0) with saturating subtract. When the new duty is 0, go DEAD and load dead_cnt<=DEAD_CYCLES-1. run re-asserting or dir toggling here is ignored; the ramp-down always completes.
  - DEAD: dead_cnt decrements each clk; at 0, go IDLE. Ctrl is ignored; a restart needs IDLE plus the next bnd.
- Output register: pwm_on = (cnt < duty), registered (1-cycle latency).
  - pwm_a = pwm_on & ~dir_act & (state in RAMP_UP/RUN/RAMP_DOWN).
  - pwm_b = pwm_on & dir_act & (same states).
  - pwm_a and pwm_b are never high together.
  - Both are low in IDLE and DEAD.
- dir_act changes only on the IDLE->RAMP_UP/RUN transition, so a direction reversal always passes through ramp-down and DEAD.
- duty_o = duty; busy = (state != IDLE).
- When DUTY_MAX == PERIOD the output is 100% on. DUTY_MAX that is not a multiple of RAMP_STEP saturates on the last step.
- Reset asserted mid-operation clears the outputs immediately; there is no ramp-down.

Decomposition:
- Package pio_pwm_pkg: state enum (IDLE, RAMP_UP, RUN, RAMP_DOWN, DEAD), a 3-bit state width constant, and a saturating add/sub helper function.
- One sub-module, pio_ctrl_sync: a SYNC_STAGES-deep, 2-bit synchronizer with async reset to 0.
- The FSM, counters and output register stay in pio_pwm_ramp.

Test Plan:
Bench parameters: PERIOD=20, DUTY_MAX=12, RAMP_STEP=4, DEAD_CYCLES=5, SYNC_STAGES=2.
1. Reset with ctrl_in=11 held -> pwm_a=pwm_b=0, duty_o=0, busy=0, state_o=IDLE for the whole reset window.
2. ctrl_in=01 -> after 2 sync cycles and the next bnd: RAMP_UP, duty_o 4,8,12 on successive boundaries, RUN entered with duty 12. Then pwm_a high exactly 12 of every 20 cycles; pwm_b=0.
3. From RUN, ctrl_in=00 -> RAMP_DOWN, duty_o 8,4,0 on boundaries. Then DEAD for exactly 5 cycles with both outputs low, then IDLE with busy=0.
4. From RUN (dir 0), ctrl_in=11 -> ramp-down, 5-cycle DEAD, IDLE, then at the next bnd ramp up on pwm_b. pwm_a&pwm_b is never 1 at any cycle, and the all-low gap is >=5 cycles.
5. RAMP_STEP=5, DUTY_MAX=12 -> duty_o 5,10,12 up, then 7,2,0 down. No underflow wrap.
6. Assert reset_n=0 mid-RUN, between clock edges -> pwm_a, busy and duty_o drop to 0 without waiting for a clk edge. On release with ctrl_in=01, the block restarts from IDLE per scenario 2.
